// File: rtl/conv3x3_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_seq_if
// Brief    : Control and BRAM port bundle for the 3x3 convolution sequencer.
// Revision : 1.0
// ============================================================================
interface conv3x3_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  istart;
  logic                  obusy;
  logic                  odone;
  logic                  oerr;
  logic                  valid_i_read;
  logic [DATA_WIDTH-1:0] value_i_read;
  logic                  valid_w_read;
  logic [DATA_WIDTH-1:0] value_w_read;
  logic                  enb_i_read;
  logic [ADDR_WIDTH-1:0] addrb_i_read;
  logic                  enb_w_read;
  logic [ADDR_WIDTH-1:0] addrb_w_read;
  logic                  ena_f_write;
  logic                  wea_f_write;
  logic [ADDR_WIDTH-1:0] addra_f_write;
  logic [DATA_WIDTH-1:0] dina_f_write;

  modport master (
    input  istart, valid_i_read, value_i_read, valid_w_read, value_w_read,
    output obusy, odone, oerr, enb_i_read, addrb_i_read, enb_w_read, addrb_w_read,
           ena_f_write, wea_f_write, addra_f_write, dina_f_write
  );

  modport slave (
    output istart, valid_i_read, value_i_read, valid_w_read, value_w_read,
    input  obusy, odone, oerr, enb_i_read, addrb_i_read, enb_w_read, addrb_w_read,
           ena_f_write, wea_f_write, addra_f_write, dina_f_write
  );
endinterface
`default_nettype wire

// File: rtl/conv3x3_seq.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_seq
// Brief    : Sequencer for a 3x3 valid convolution over a BRAM feature map.
// Revision : 1.0
// ============================================================================
module conv3x3_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int FRAC_BITS  = 8
) (
  input  wire logic     iclk,
  input  wire logic     irst,
  conv3x3_seq_if.master bus
);

  localparam int c_prod_w = 2 * DATA_WIDTH;
  localparam int c_acc_w  = 2 * DATA_WIDTH + 4;

  localparam logic [ADDR_WIDTH-1:0] c_one       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_row_step  = ADDR_WIDTH'(IMG_W - 2);
  localparam logic [ADDR_WIDTH-1:0] c_line_wrap = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] c_last_col  = ADDR_WIDTH'(IMG_W - 3);
  localparam logic [ADDR_WIDTH-1:0] c_last_row  = ADDR_WIDTH'(IMG_H - 3);

  localparam logic signed [c_acc_w-1:0] c_sat_max =
    {{(c_acc_w - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [c_acc_w-1:0] c_sat_min =
    {{(c_acc_w - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] c_res_max = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] c_res_min = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3:0]                   r_tap;
  logic [1:0]                   r_kx;
  logic [ADDR_WIDTH-1:0]        r_row;
  logic [ADDR_WIDTH-1:0]        r_col;
  logic [ADDR_WIDTH-1:0]        r_base;
  logic [ADDR_WIDTH-1:0]        r_addr_i;
  logic [ADDR_WIDTH-1:0]        r_out_addr;
  logic [ADDR_WIDTH-1:0]        r_addra;
  logic [DATA_WIDTH-1:0]        r_dina;
  logic signed [c_acc_w-1:0]    r_acc;
  logic [3:0]                   r_cnt;
  logic                         r_err;

  logic                         w_pair;
  logic                         w_start;
  logic                         w_last_pix;
  logic [ADDR_WIDTH-1:0]        w_base_nxt;
  logic signed [c_prod_w-1:0]   w_op_i;
  logic signed [c_prod_w-1:0]   w_op_w;
  logic signed [c_prod_w-1:0]   w_prod;
  logic signed [c_acc_w-1:0]    w_prod_ext;
  logic signed [c_acc_w-1:0]    w_acc_sum;
  logic signed [c_acc_w-1:0]    w_acc_nxt;
  logic signed [c_acc_w-1:0]    w_shifted;
  logic [DATA_WIDTH-1:0]        w_result;
  logic                         w_busy;
  logic                         w_done;
  logic                         w_rd_en;
  logic                         w_wr_en;

  assign w_pair  = bus.valid_i_read & bus.valid_w_read;
  assign w_start = (r_state == S_IDLE) & bus.istart;

  // Operands are widened first so the product is exact at full width.
  assign w_op_i     = {{DATA_WIDTH{bus.value_i_read[DATA_WIDTH-1]}}, bus.value_i_read};
  assign w_op_w     = {{DATA_WIDTH{bus.value_w_read[DATA_WIDTH-1]}}, bus.value_w_read};
  assign w_prod     = w_op_i * w_op_w;
  assign w_prod_ext = {{4{w_prod[c_prod_w-1]}}, w_prod};
  assign w_acc_sum  = r_acc + w_prod_ext;
  assign w_acc_nxt  = w_pair ? w_acc_sum : r_acc;
  assign w_shifted  = w_acc_nxt >>> FRAC_BITS;

  always_comb begin
    w_result = w_shifted[DATA_WIDTH-1:0];
    if (w_shifted > c_sat_max) begin
      w_result = c_res_max;
    end else if (w_shifted < c_sat_min) begin
      w_result = c_res_min;
    end
  end

  assign w_last_pix = (r_row == c_last_row) && (r_col == c_last_col);
  assign w_base_nxt = (r_col == c_last_col) ? (r_base + c_line_wrap) : (r_base + c_one);

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.istart) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_rd_en = 1'b1;
        if (r_tap == 4'd8) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((r_cnt == 4'd9) || ((r_cnt == 4'd8) && w_pair)) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_wr_en     = 1'b1;
        w_state_nxt = w_last_pix ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Window walk: r_base is the top-left input pixel, r_addr_i the current tap.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_tap      <= 4'd0;
      r_kx       <= 2'd0;
      r_row      <= '0;
      r_col      <= '0;
      r_base     <= '0;
      r_addr_i   <= '0;
      r_out_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.istart) begin
            r_tap      <= 4'd0;
            r_kx       <= 2'd0;
            r_row      <= '0;
            r_col      <= '0;
            r_base     <= '0;
            r_addr_i   <= '0;
            r_out_addr <= '0;
          end
        end
        S_ISSUE: begin
          if (r_tap != 4'd8) begin
            r_tap    <= r_tap + 4'd1;
            r_kx     <= (r_kx == 2'd2) ? 2'd0 : (r_kx + 2'd1);
            r_addr_i <= r_addr_i + ((r_kx == 2'd2) ? c_row_step : c_one);
          end
        end
        S_WRITE: begin
          if (!w_last_pix) begin
            r_tap      <= 4'd0;
            r_kx       <= 2'd0;
            r_base     <= w_base_nxt;
            r_addr_i   <= w_base_nxt;
            r_out_addr <= r_out_addr + c_one;
            if (r_col == c_last_col) begin
              r_col <= '0;
              r_row <= r_row + c_one;
            end else begin
              r_col <= r_col + c_one;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_acc <= '0;
      r_cnt <= 4'd0;
      r_err <= 1'b0;
    end else if (w_start) begin
      r_acc <= '0;
      r_cnt <= 4'd0;
      r_err <= 1'b0;
    end else begin
      // A pair landing in WRITE already belongs to the next pixel.
      if (r_state == S_WRITE) begin
        r_acc <= w_pair ? w_prod_ext : '0;
        r_cnt <= w_pair ? 4'd1 : 4'd0;
      end else if (w_pair) begin
        r_acc <= w_acc_sum;
        if (r_cnt != 4'd9) begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
      if ((bus.valid_i_read ^ bus.valid_w_read) ||
          (w_pair && (r_cnt == 4'd9)) ||
          (w_pair && (r_state == S_IDLE))) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_addra <= '0;
      r_dina  <= '0;
    end else if ((r_state == S_DRAIN) && (w_state_nxt == S_WRITE)) begin
      r_addra <= r_out_addr;
      r_dina  <= w_result;
    end
  end

  assign bus.obusy         = w_busy;
  assign bus.odone         = w_done;
  assign bus.oerr          = r_err;
  assign bus.enb_i_read    = w_rd_en;
  assign bus.enb_w_read    = w_rd_en;
  assign bus.addrb_i_read  = r_addr_i;
  assign bus.addrb_w_read  = {{(ADDR_WIDTH - 4){1'b0}}, r_tap};
  assign bus.ena_f_write   = w_wr_en;
  assign bus.wea_f_write   = w_wr_en;
  assign bus.addra_f_write = r_addra;
  assign bus.dina_f_write  = r_dina;

endmodule
`default_nettype wire
